alarm_bank: RTL and testbench
=============================

ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent alarm channels (1..8).
REQ-002 Parameter DELAY_W, default 8: width of the programmable arm-to-alert delay.
REQ-003 Parameter DEB_CYCLES, default 4: released-button cycles required before the next press is accepted (1..65535).
REQ-004 Parameter SNOOZE_CYC, default 16: snooze duration in cycles (>=1).
REQ-005 Parameter MAX_SNOOZE, default 3: snoozes allowed per alert episode (0..15).
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous and active-high (1 = reset).
REQ-008 btn_n  input  NCH  raw asynchronous per-channel buttons, active-low (0 = pressed).
REQ-009 delay_cfg  input  DELAY_W  arm delay, sampled when a channel enters ARMED.
REQ-010 snooze  input  1  global synchronous snooze request, level-sampled each cycle.
REQ-011 alert  output  NCH  per-channel alert, 1 while channel is in ALERT.
REQ-012 any_alert  output  1  OR of alert.
REQ-013 first_idx  output  3  index of lowest-numbered alerting channel; 0 when none.
REQ-014 armed  output  NCH  per-channel, 1 while in ARMED or SNOOZE.

Function
REQ-015 Each btn_n bit SHALL pass through a two-flop synchronizer (reset value 1) before any use.
REQ-016 Per channel, a one-cycle press pulse SHALL fire when synced button is 0 and lockout counter is 0; on the pulse, lockout loads DEB_CYCLES.
REQ-017 Lockout SHALL decrement by 1 only in cycles where synced button is 1 and lockout > 0; holding the button never produces a second pulse.
REQ-018 Latency: btn_n sampled 0 at edge E0 (lockout 0) -> channel state change at edge E2.
REQ-019 Per-channel FSM states: IDLE, ARMED, ALERT, SNOOZE; each channel has a DELAY_W-bit (min 5-bit for SNOOZE_CYC) down-counter and a snooze tally.
REQ-020 IDLE + press -> ARMED, counter := delay_cfg.
REQ-021 ARMED: counter == 0 -> ALERT; else counter decrements; ARMED lasts delay_cfg+1 cycles (delay_cfg = 0 -> 1 cycle).
REQ-022 ARMED + press -> IDLE (cancel), taking priority over expiry in the same cycle.
REQ-023 ALERT + press -> IDLE (acknowledge), snooze tally := 0.
REQ-024 ALERT + snooze=1 + press=0 + tally < MAX_SNOOZE -> SNOOZE, counter := SNOOZE_CYC-1, tally += 1; when tally == MAX_SNOOZE, snooze is ignored.
REQ-025 SNOOZE: counter == 0 -> ALERT; else decrement; press -> IDLE with tally := 0 (press has priority).
REQ-026 snooze acts on every channel in ALERT during that cycle; channels in other states ignore it.
REQ-027 Channels SHALL be fully independent; simultaneous presses on several channels each act in the same cycle.
REQ-028 alert, any_alert, first_idx, armed SHALL be decoded combinationally from registered state only (no input-to-output paths).
REQ-029 first_idx SHALL report lowest index i with alert[i]=1.
REQ-030 Unreachable state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-031 rst_n=1 at an edge SHALL force all channels to IDLE, counters, tallies and lockouts to 0, synchronizers to 1, regardless of current state including mid-count.
REQ-032 During and after reset: alert=0, any_alert=0, first_idx=0, armed=0; a button held through reset is accepted as a press at the second edge after release of reset.

Verification
REQ-033 Arm: delay_cfg=5, btn_n[0] low one cycle at E0 -> armed[0]=1 after E2, alert[0]=1 after E8, any_alert=1, first_idx=0.
REQ-034 Cancel/debounce: hold btn_n[1] low 20 cycles after arming -> single press only; release 3 cycles then press -> ignored (DEB_CYCLES=4); release 4 cycles then press -> channel 1 returns IDLE.
REQ-035 Snooze: channel 2 in ALERT, snooze=1 one cycle -> alert[2]=0 for 16 cycles then 1; repeat three times; fourth snooze ignored, alert[2] stays 1.
REQ-036 Priority: channels 1 and 3 alerting -> first_idx=1; acknowledge channel 1 -> first_idx=3; press and expiry same cycle in ARMED -> IDLE.
REQ-037 Reset mid-operation: rst_n=1 one cycle while channel 0 in SNOOZE and channel 3 ALERT -> all outputs 0 next cycle, subsequent arm with delay_cfg=0 alerts at E3.

Source files
------------

// File: rtl/alarm_bank_if.sv
// rtl/alarm_bank_if.sv - button/config inputs and alarm status outputs of alarm_bank
interface alarm_bank_if #(
    parameter int NCH     = 4,
    parameter int DELAY_W = 8
);
    logic [NCH-1:0]     btn_n;
    logic [DELAY_W-1:0] delay_cfg;
    logic               snooze;
    logic [NCH-1:0]     alert;
    logic               any_alert;
    logic [2:0]         first_idx;
    logic [NCH-1:0]     armed;

    modport master (
        output btn_n, delay_cfg, snooze,
        input  alert, any_alert, first_idx, armed
    );

    modport slave (
        input  btn_n, delay_cfg, snooze,
        output alert, any_alert, first_idx, armed
    );
endinterface

// File: rtl/alarm_bank.sv
// rtl/alarm_bank.sv - bank of independent debounced alarm channels with arm delay and snooze
module alarm_bank #(
    parameter int NCH        = 4,
    parameter int DELAY_W    = 8,
    parameter int DEB_CYCLES = 4,
    parameter int SNOOZE_CYC = 16,
    parameter int MAX_SNOOZE = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    alarm_bank_if.slave bus
);
    localparam int SW = ($clog2(SNOOZE_CYC + 1) < 5) ? 5 : $clog2(SNOOZE_CYC + 1);
    localparam int CW = (DELAY_W > SW) ? DELAY_W : SW;

    typedef enum logic [1:0] {IDLE, ARMED, ALERT, SNOOZE} state_t;

    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;
    logic [NCH-1:0] w_press;
    logic [NCH-1:0] w_alert;
    logic [NCH-1:0] w_armed;
    logic [2:0]     w_first;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= bus.btn_n;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t      r_state;
        logic [CW-1:0] r_cnt;
        logic [3:0]  r_tally;
        logic [15:0] r_lock;

        // Lockout only drains while released, so a held button can never re-fire.
        assign w_press[g] = ~r_sync2[g] && (r_lock == 16'd0);

        always_ff @(posedge clk) begin
            if (rst_n) begin
                r_lock <= '0;
            end else if (w_press[g]) begin
                r_lock <= 16'(DEB_CYCLES);
            end else if (r_sync2[g] && (r_lock != 16'd0)) begin
                r_lock <= r_lock - 16'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst_n) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_tally <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_press[g]) begin
                            r_state <= ARMED;
                            r_cnt   <= CW'(bus.delay_cfg);
                        end
                    end
                    ARMED: begin
                        if (w_press[g]) begin
                            r_state <= IDLE;
                        end else if (r_cnt == '0) begin
                            r_state <= ALERT;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ALERT: begin
                        if (w_press[g]) begin
                            r_state <= IDLE;
                            r_tally <= '0;
                        end else if (bus.snooze && (r_tally < 4'(MAX_SNOOZE))) begin
                            r_state <= SNOOZE;
                            r_cnt   <= CW'(SNOOZE_CYC - 1);
                            r_tally <= r_tally + 4'd1;
                        end
                    end
                    SNOOZE: begin
                        if (w_press[g]) begin
                            r_state <= IDLE;
                            r_tally <= '0;
                        end else if (r_cnt == '0) begin
                            r_state <= ALERT;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_tally <= '0;
                    end
                endcase
            end
        end

        assign w_alert[g] = (r_state == ALERT);
        assign w_armed[g] = (r_state == ARMED) || (r_state == SNOOZE);
    end

    always_comb begin
        w_first = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_alert[i]) begin
                w_first = 3'(i);
            end
        end
    end

    assign bus.alert     = w_alert;
    assign bus.any_alert = |w_alert;
    assign bus.first_idx = w_first;
    assign bus.armed     = w_armed;
endmodule

// File: tb/tb_alarm_bank.sv
// tb/tb_alarm_bank.sv - directed self-checking bench for alarm_bank
module tb_alarm_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    alarm_bank_if #(.NCH(4), .DELAY_W(8)) bus ();

    alarm_bank #(
        .NCH(4), .DELAY_W(8), .DEB_CYCLES(4), .SNOOZE_CYC(16), .MAX_SNOOZE(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] m);
        bus.btn_n = ~m;
        tick(1);
        bus.btn_n = '1;
    endtask

    task automatic pulse_gap(input logic [3:0] m, input int gap);
        pulse(m);
        tick(gap);
        pulse(m);
        tick(3);
    endtask

    initial begin
        bus.btn_n     = '1;
        bus.delay_cfg = '0;
        bus.snooze    = 1'b0;
        tick(2);
        chk("rst_alert", 32'(bus.alert), 32'h0);
        chk("rst_any", 32'(bus.any_alert), 32'h0);
        chk("rst_first", 32'(bus.first_idx), 32'h0);
        chk("rst_armed", 32'(bus.armed), 32'h0);
        rst_n = 1'b0;

        // arm channel 0 with delay 5
        bus.delay_cfg = 8'd5;
        pulse(4'b0001);
        tick(1);
        chk("arm_e1", 32'(bus.armed), 32'h0);
        tick(1);
        chk("arm_e2", 32'(bus.armed), 32'h1);
        tick(5);
        chk("arm_e7", 32'(bus.alert), 32'h0);
        tick(1);
        chk("arm_e8_alert", 32'(bus.alert), 32'h1);
        chk("arm_e8_any", 32'(bus.any_alert), 32'h1);
        chk("arm_e8_first", 32'(bus.first_idx), 32'h0);
        chk("arm_e8_armed", 32'(bus.armed), 32'h0);
        pulse(4'b0001);
        tick(2);
        chk("ack0_alert", 32'(bus.alert), 32'h0);
        chk("ack0_any", 32'(bus.any_alert), 32'h0);

        // debounce on channel 1
        bus.delay_cfg = 8'd200;
        pulse_gap(4'b0010, 4);
        chk("gap4_cancel", 32'(bus.armed), 32'h0);
        tick(6);
        pulse_gap(4'b0010, 3);
        chk("gap3_ignored", 32'(bus.armed), 32'h2);
        tick(2);
        bus.btn_n = 4'b1101;
        tick(3);
        chk("hold_cancel", 32'(bus.armed), 32'h0);
        tick(17);
        chk("hold_single", 32'(bus.armed), 32'h0);
        bus.btn_n = '1;
        tick(8);

        // snooze on channel 2
        bus.delay_cfg = 8'd2;
        pulse(4'b0100);
        tick(4);
        chk("c2_e4", 32'(bus.alert), 32'h0);
        tick(1);
        chk("c2_alert", 32'(bus.alert), 32'h4);
        for (int k = 0; k < 3; k++) begin
            bus.snooze = 1'b1;
            tick(1);
            bus.snooze = 1'b0;
            chk($sformatf("snz%0d_off", k), 32'(bus.alert), 32'h0);
            chk($sformatf("snz%0d_armed", k), 32'(bus.armed), 32'h4);
            tick(15);
            chk($sformatf("snz%0d_15", k), 32'(bus.alert), 32'h0);
            tick(1);
            chk($sformatf("snz%0d_back", k), 32'(bus.alert), 32'h4);
        end
        bus.snooze = 1'b1;
        tick(1);
        bus.snooze = 1'b0;
        chk("snz4_ignored", 32'(bus.alert), 32'h4);
        tick(3);
        chk("snz4_still", 32'(bus.alert), 32'h4);
        pulse(4'b0100);
        tick(2);
        chk("ack2", 32'(bus.alert), 32'h0);
        tick(6);
        bus.delay_cfg = 8'd0;
        pulse(4'b0100);
        tick(3);
        chk("c2_rearm", 32'(bus.alert), 32'h4);
        bus.snooze = 1'b1;
        tick(1);
        bus.snooze = 1'b0;
        chk("tally_cleared", 32'(bus.alert), 32'h0);
        tick(4);
        pulse(4'b0100);
        tick(2);
        chk("snz_press_armed", 32'(bus.armed), 32'h0);
        chk("snz_press_alert", 32'(bus.alert), 32'h0);

        // priority encoding and press-vs-expiry
        tick(6);
        bus.delay_cfg = 8'd1;
        pulse(4'b1010);
        tick(4);
        chk("pri_alert", 32'(bus.alert), 32'ha);
        chk("pri_first1", 32'(bus.first_idx), 32'h1);
        pulse(4'b0010);
        tick(2);
        chk("pri_first3", 32'(bus.first_idx), 32'h3);
        chk("pri_alert3", 32'(bus.alert), 32'h8);
        pulse(4'b1000);
        tick(2);
        chk("pri_none_any", 32'(bus.any_alert), 32'h0);
        chk("pri_none_first", 32'(bus.first_idx), 32'h0);
        tick(6);
        bus.delay_cfg = 8'd6;
        pulse(4'b0001);
        tick(6);
        bus.btn_n = 4'b1110;
        tick(1);
        bus.btn_n = '1;
        tick(1);
        chk("race_e8", 32'(bus.armed), 32'h1);
        tick(1);
        chk("race_armed", 32'(bus.armed), 32'h0);
        chk("race_alert", 32'(bus.alert), 32'h0);
        tick(3);
        chk("race_later", 32'(bus.alert), 32'h0);

        // reset mid-operation
        tick(6);
        bus.delay_cfg = 8'd0;
        pulse(4'b0001);
        tick(3);
        chk("mid_c0_alert", 32'(bus.alert), 32'h1);
        bus.snooze = 1'b1;
        tick(1);
        bus.snooze = 1'b0;
        tick(4);
        pulse(4'b1000);
        tick(3);
        chk("mid_alert", 32'(bus.alert), 32'h8);
        chk("mid_armed", 32'(bus.armed), 32'h1);
        rst_n = 1'b1;
        tick(1);
        rst_n = 1'b0;
        chk("mid_rst_alert", 32'(bus.alert), 32'h0);
        chk("mid_rst_armed", 32'(bus.armed), 32'h0);
        chk("mid_rst_any", 32'(bus.any_alert), 32'h0);
        chk("mid_rst_first", 32'(bus.first_idx), 32'h0);
        pulse(4'b0001);
        tick(1);
        tick(1);
        chk("post_e2_armed", 32'(bus.armed), 32'h1);
        chk("post_e2_alert", 32'(bus.alert), 32'h0);
        tick(1);
        chk("post_e3_alert", 32'(bus.alert), 32'h1);

        // button held through reset
        rst_n = 1'b1;
        bus.btn_n = 4'b1101;
        tick(2);
        chk("hold_rst_armed", 32'(bus.armed), 32'h0);
        chk("hold_rst_alert", 32'(bus.alert), 32'h0);
        rst_n = 1'b0;
        tick(2);
        chk("hold_rel_r2", 32'(bus.armed), 32'h0);
        tick(1);
        chk("hold_rel_r3", 32'(bus.armed), 32'h2);
        bus.btn_n = '1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
